// File: rtl/store_packer_if.sv
// Store request / packed memory write bus for store_packer.
// Upstream request handshake (in_*) and downstream memory write handshake (out_*).
interface store_packer_if #(
    parameter int unsigned addrBits = 32,
    parameter int unsigned dataBits = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [dataBits-1:0] in_data;
    logic [addrBits-1:0] in_addr;
    logic [1:0]          in_size;
    logic                out_valid;
    logic                out_ready;
    logic [addrBits-1:0] out_addr;
    logic [dataBits-1:0] out_wdata;
    logic [3:0]          out_be;
    logic                out_err;

    // Requester / memory side: drives requests, consumes writes.
    modport master (
        output in_valid, in_data, in_addr, in_size, out_ready,
        input  in_ready, out_valid, out_addr, out_wdata, out_be, out_err
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, in_addr, in_size, out_ready,
        output in_ready, out_valid, out_addr, out_wdata, out_be, out_err
    );
endinterface

// File: rtl/store_packer.sv
// store_packer: steers a store's register data onto little-endian byte lanes,
// builds byte enables, and buffers the packed write in a 2-entry FIFO
// (1-cycle latency, full throughput).
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned half/word stores are enqueued
// with out_be=0000 and out_err=1 instead of being silently aligned.
module store_packer #(
    parameter int unsigned addrBits = 32,
    parameter int unsigned dataBits = 32
) (
    input logic              clk,
    input logic              reset,
    store_packer_if.slave    bus
);

    typedef struct packed {
        logic [addrBits-1:0] addr;
        logic [dataBits-1:0] wdata;
        logic [3:0]          be;
        logic                err;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e state_q, state_d;
    entry_t slot0_q, slot0_d;  // head
    entry_t slot1_q, slot1_d;
    entry_t pack;

    logic in_ready, out_valid, push, pop;
    logic [addrBits-1:0] out_addr;
    logic [dataBits-1:0] out_wdata;
    logic [3:0]          out_be;
    logic                out_err;

    // Pack the incoming request into a memory write entry.
    always_comb begin
        pack       = '0;
        pack.addr  = {bus.in_addr[addrBits-1:2], 2'b00};
        pack.wdata = bus.in_data;
        case (bus.in_size)
            2'b00: begin
                pack.wdata = {4{bus.in_data[7:0]}};
                pack.be    = 4'b0001 << bus.in_addr[1:0];
            end
            2'b01: begin
                pack.wdata = {2{bus.in_data[15:0]}};
                pack.be    = bus.in_addr[1] ? 4'b1100 : 4'b0011;
`ifdef STORE_MISALIGN_TRAP_EN
                if (bus.in_addr[0]) begin
                    pack.be  = 4'b0000;
                    pack.err = 1'b1;
                end
`endif
            end
            2'b10: begin
                pack.be = 4'b1111;
`ifdef STORE_MISALIGN_TRAP_EN
                if (bus.in_addr[1:0] != 2'b00) begin
                    pack.be  = 4'b0000;
                    pack.err = 1'b1;
                end
`endif
            end
            default: pack.be = 4'b0000;  // reserved size: passes through, no lanes enabled
        endcase
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state and FIFO slot updates.
    always_comb begin
        state_d = state_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    slot0_d = pack;
                end
            end
            StOne: begin
                case ({push, pop})
                    2'b10: begin
                        state_d = StTwo;
                        slot1_d = pack;
                    end
                    2'b01: begin
                        state_d = StEmpty;
                        slot0_d = '0;
                    end
                    2'b11: slot0_d = pack;  // head retires, new entry becomes head
                    default: ;
                endcase
            end
            StTwo: begin
                if (pop) begin
                    state_d = StOne;
                    slot0_d = slot1_q;
                    slot1_d = '0;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // FIFO slot registers; reset discards anything pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0_q <= '0;
            slot1_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
        end
    end

    // Handshake and head-entry outputs, all decoded from registered state.
    always_comb begin
        in_ready  = (state_q != StTwo);
        out_valid = (state_q != StEmpty);
        push      = bus.in_valid & in_ready;
        pop       = out_valid & bus.out_ready;
        out_addr  = '0;
        out_wdata = '0;
        out_be    = '0;
        out_err   = 1'b0;
        if (out_valid) begin
            out_addr  = slot0_q.addr;
            out_wdata = slot0_q.wdata;
            out_be    = slot0_q.be;
            out_err   = slot0_q.err;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_addr  = out_addr;
    assign bus.out_wdata = out_wdata;
    assign bus.out_be    = out_be;
    assign bus.out_err   = out_err;

endmodule

// File: doc/store_packer.md
STORE_PACKER -- requirements
Module: store_packer

Interface
REQ-001 The block SHALL have parameter addrBits, default 32, meaning the width of the byte address on input and output.
REQ-002 The block SHALL have parameter dataBits, default 32, meaning the width of the register data and the memory word; only 32 is supported.
REQ-003 clk  input  1  the single clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 in_valid  input  1  the upstream store request is valid.
REQ-006 in_ready  output  1  the block accepts a request this cycle.
REQ-007 in_data  input  dataBits  the unnarrowed register value to store.
REQ-008 in_addr  input  addrBits  the byte address.
REQ-009 in_size  input  2  the store size: 00 byte (SB), 01 half (SH), 10 word (SW), 11 reserved.
REQ-010 out_valid  output  1  a packed memory write is available.
REQ-011 out_ready  input  1  memory accepts the write this cycle.
REQ-012 out_addr  output  addrBits  the word address, which is in_addr with bits [1:0] forced to 0.
REQ-013 out_wdata  output  dataBits  the data, replicated or steered onto its byte lanes.
REQ-014 out_be  output  4  the byte enables; bit i enables lane i (bits 8i+7:8i).
REQ-015 out_err  output  1  the current output entry is a misaligned store (only when STORE_MISALIGN_TRAP_EN is defined).

Function
REQ-016 A request SHALL transfer when in_valid and in_ready are both 1 in the same cycle; an output entry SHALL retire when out_valid and out_ready are both 1 in the same cycle.
REQ-017 Lane mapping SHALL be little-endian, with lane equal to in_addr[1:0].
- Byte: in_data[7:0] is replicated to all 4 lanes; be = 0001 shifted left by addr[1:0].
- Half: in_data[15:0] is replicated to both halves; be = 0011 when addr[1]=0, 1100 when addr[1]=1.
- Word: in_data is passed unchanged; be = 1111.
REQ-018 A reserved size (11) SHALL produce out_be=0000 and out_wdata=in_data, and SHALL still occupy one entry and retire normally.
REQ-019 Packing SHALL be computed on the input side and stored in a 2-entry FIFO, so an accepted request is visible at the output in the next cycle (1-cycle latency), in order.
REQ-020 The occupancy state machine SHALL have states EMPTY, ONE and TWO:
- EMPTY: a push moves to ONE.
- ONE: a push alone moves to TWO; a pop alone moves to EMPTY; a push and pop together stay in ONE, with the new entry becoming the head next cycle.
- TWO: a pop moves to ONE; no push is possible.
REQ-021 in_ready SHALL be 1 exactly when the state is not TWO, and SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-023 out_addr, out_wdata, out_be and out_err SHALL come from the head entry, and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 When out_valid=0, out_wdata, out_addr and out_be SHALL be 0.
REQ-025 Back-to-back full throughput (one request per cycle) SHALL be sustained while out_ready=1.

Reset
REQ-026 When reset=1 at a clock edge, the state SHALL become EMPTY and all entries SHALL be cleared, regardless of any handshake in that cycle.
REQ-027 After reset: in_ready=1, out_valid=0, out_addr=0, out_wdata=0, out_be=0000, out_err=0.
REQ-028 A reset asserted while entries are pending SHALL discard them; no discarded entry SHALL appear at the output.

Configuration
REQ-029 Macro STORE_MISALIGN_TRAP_EN SHALL select the misaligned-store handling.
REQ-030 With STORE_MISALIGN_TRAP_EN defined:
- A half with addr[0]=1, or a word with addr[1:0]!=00, SHALL be enqueued with out_be=0000 and out_err=1.
- The entry SHALL still retire via the handshake.
REQ-031 Without STORE_MISALIGN_TRAP_EN:
- out_err SHALL be constant 0.
- A misaligned half SHALL use addr[1] only; a misaligned word SHALL use be=1111 (low address bits ignored).

Verification
REQ-032 Reset, then SB with in_data=0x000000A5, addr=0x1003, out_ready=1 -> next cycle out_addr=0x1000, out_wdata=0xA5A5A5A5, out_be=1000.
REQ-033 SH with in_data=0x1234BEEF, addr=0x2002 -> out_wdata=0xBEEFBEEF, out_be=1100; SW 0xDEADBEEF at 0x2000 -> out_be=1111, out_wdata unchanged.
REQ-034 out_ready=0 with 3 consecutive valid requests -> first two accepted, in_ready=0 on the third cycle; raise out_ready -> outputs retire in order with no loss or duplication.
REQ-035 Simultaneous push and pop in ONE for 8 cycles -> in_ready stays 1, out_valid stays 1, 8 entries emerge in order.
REQ-036 SW at 0x3001 -> with the macro: out_be=0000, out_err=1; without it: out_be=1111, out_err=0.
REQ-037 With 2 entries pending, assert reset for 1 cycle -> out_valid=0 the following cycle; a new SB then emerges alone.
